// File: rtl/lint_mem_slave.sv
// rtl/lint_mem_slave.sv - lint req/gnt/rvalid responder backed by a byte-enabled word memory
// Programmable grant wait states, one outstanding response, sticky out-of-range flag.
module lint_mem_slave #(
  parameter int                 ADDR_WD   = 32,
  parameter int                 DATA_WD   = 32,
  parameter int                 BE_WD     = DATA_WD / 8,
  parameter int                 DEPTH     = 1024,
  parameter logic [ADDR_WD-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int                 WAIT_WD   = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               lint_req_i,
  input  logic               lint_we_i,
  input  logic [ADDR_WD-1:0] lint_addr_i,
  input  logic [DATA_WD-1:0] lint_wdata_i,
  input  logic [BE_WD-1:0]   lint_be_i,
  output logic               lint_gnt_o,
  output logic               lint_rvalid_o,
  output logic [DATA_WD-1:0] lint_rdata_o,
  input  logic [WAIT_WD-1:0] wait_cycles_i,
  output logic               oor_err_o,
  input  logic               oor_clr_i
);

  localparam int OFF_BITS = $clog2(BE_WD);
  localparam int IDX_WD   = $clog2(DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t             state;
  logic [WAIT_WD-1:0] cnt;
  logic [ADDR_WD-1:0] off;
  logic [ADDR_WD-1:0] idx;
  logic               in_range;
  logic [DATA_WD-1:0] mem [DEPTH];

  // Offset wraps modulo 2^ADDR_WD, so addresses below the base need the explicit >= test.
  assign off      = lint_addr_i - BASE_ADDR;
  assign idx      = off >> OFF_BITS;
  assign in_range = (lint_addr_i >= BASE_ADDR) && (idx < ADDR_WD'(DEPTH));

  always_comb begin
    lint_gnt_o = 1'b0;
    case (state)
      ST_IDLE: lint_gnt_o = lint_req_i && (wait_cycles_i == '0);
      ST_WAIT: lint_gnt_o = lint_req_i && (cnt == '0);
      default: lint_gnt_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      lint_rvalid_o <= 1'b0;
      lint_rdata_o  <= '0;
      oor_err_o     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // The wait count is captured here so later wait_cycles_i changes cannot shorten it.
          if (lint_req_i && (wait_cycles_i != '0)) begin
            cnt   <= wait_cycles_i - WAIT_WD'(1);
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!lint_req_i || (cnt == '0)) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - WAIT_WD'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase

      lint_rvalid_o <= lint_gnt_o;
      if (lint_gnt_o) begin
        lint_rdata_o <= (!lint_we_i && in_range) ? mem[idx[IDX_WD-1:0]] : '0;
      end

      if (lint_gnt_o && !in_range) begin
        oor_err_o <= 1'b1;
      end else if (oor_clr_i) begin
        oor_err_o <= 1'b0;
      end
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk_i) begin
    if (lint_gnt_o && lint_we_i && in_range) begin
      for (int k = 0; k < BE_WD; k++) begin
        if (lint_be_i[k]) begin
          mem[idx[IDX_WD-1:0]][8*k +: 8] <= lint_wdata_i[8*k +: 8];
        end
      end
    end
  end

endmodule
